dac_event_sequencer: RTL and testbench



---
 rtl/dac_seq_pkg.sv | 26 ++
 rtl/dac_event_sequencer_if.sv | 27 ++
 rtl/dac_seq_fifo.sv | 51 +++++
 rtl/dac_event_sequencer.sv | 132 +++++++++++++
 tb/tb_dac_event_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_seq_pkg.sv
// Shared types and field layout for the DAC event sequencer.
// Event word: [127:64] ts, [63:56] channel, [55:52] opcode, [51:0] payload.
package dac_seq_pkg;

    localparam int EVT_W  = 128;
    localparam int TS_MSB = 127;
    localparam int TS_LSB = 64;
    localparam int CH_MSB = 63;
    localparam int CH_LSB = 56;
    localparam int OP_MSB = 55;
    localparam int OP_LSB = 52;
    localparam int FREQ_W = 48;
    localparam int AMP_W  = 14;

    typedef enum logic [3:0] {
        OP_SET_FREQ      = 4'd0,
        OP_SET_AMP_PHASE = 4'd1,
        OP_SET_OFFSET    = 4'd2,
        OP_SET_MODE      = 4'd3
    } opcode_e;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= 4'd3;
    endfunction

endpackage

// File: rtl/dac_event_sequencer_if.sv
// Event write port of the sequencer: strobe, event word and
// per-channel FIFO status flags.
interface dac_event_sequencer_if #(
    parameter int N_CH = 4
);
    import dac_seq_pkg::*;

    logic             wr_en;
    logic [EVT_W-1:0] din;
    logic [N_CH-1:0]  full;
    logic [N_CH-1:0]  empty;

    modport master (
        output wr_en,
        output din,
        input  full,
        input  empty
    );

    modport slave (
        input  wr_en,
        input  din,
        output full,
        output empty
    );

endinterface

// File: rtl/dac_seq_fifo.sv
// First-word-fall-through synchronous FIFO with flush.
// Pointers carry one extra wrap bit to tell full from empty.
module dac_seq_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign rdata = mem[rptr[AW-1:0]];

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/dac_event_sequencer.sv
// Routes timestamped events to per-channel FIFOs and applies each head
// to its channel's DDS parameter registers once the counter reaches it.
module dac_event_sequencer
    import dac_seq_pkg::*;
#(
    parameter int          N_CH     = 4,
    parameter int          DEPTH    = 16,
    parameter logic [63:0] LATE_TOL = 64'd0
) (
    input  logic                     s_axi_aclk,
    input  logic                     s_axi_aresetn,
    input  logic                     run,
    input  logic                     flush,
    input  logic                     err_clr,
    input  logic [63:0]              counter,
    dac_event_sequencer_if.slave     wr,
    output logic [FREQ_W*N_CH-1:0]   freq,
    output logic [AMP_W*N_CH-1:0]    amp,
    output logic [AMP_W*N_CH-1:0]    phase,
    output logic [AMP_W*N_CH-1:0]    amp_offset,
    output logic [N_CH-1:0]          dac_mode,
    output logic [N_CH-1:0]          update,
    output logic [N_CH-1:0]          overflow_err,
    output logic [N_CH-1:0]          late_err,
    output logic                     chan_err
);

    logic [7:0]       wr_ch;
    logic [3:0]       wr_op;
    logic             ch_ok;
    logic             op_ok;
    logic             bad_set;
    logic [N_CH-1:0]  sel;
    logic [N_CH-1:0]  push;
    logic [N_CH-1:0]  ovf_set;
    logic [N_CH-1:0]  pop;
    logic [N_CH-1:0]  late;
    logic [N_CH-1:0]  fifo_full;
    logic [N_CH-1:0]  fifo_empty;
    logic [EVT_W-1:0] head [N_CH];

    assign wr_ch = wr.din[CH_MSB:CH_LSB];
    assign wr_op = wr.din[OP_MSB:OP_LSB];
    assign ch_ok = wr_ch < 8'(N_CH);
    assign op_ok = op_legal(wr_op);

    // flush swallows a coincident write silently, so it also masks errors
    assign bad_set = wr.wr_en && !flush && !(ch_ok && op_ok);

    assign wr.full  = fifo_full;
    assign wr.empty = fifo_empty;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [63:0]       ts;
        logic [FREQ_W-1:0] freq_r;
        logic [AMP_W-1:0]  amp_r;
        logic [AMP_W-1:0]  phase_r;
        logic [AMP_W-1:0]  ofs_r;
        logic              mode_r;
        logic              unused_bits;

        assign sel[c] = wr.wr_en && !flush && ch_ok && op_ok &&
                        (wr_ch == 8'(c));
        assign push[c]    = sel[c] && !fifo_full[c];
        assign ovf_set[c] = sel[c] && fifo_full[c];

        assign ts      = head[c][TS_MSB:TS_LSB];
        assign pop[c]  = run && !flush && !fifo_empty[c] &&
                         (counter >= ts);
        assign late[c] = (counter - ts) > LATE_TOL;

        assign unused_bits = ^{head[c][CH_MSB:CH_LSB], head[c][51:48]};

        dac_seq_fifo #(
            .DEPTH (DEPTH),
            .W     (EVT_W)
        ) u_fifo (
            .clk   (s_axi_aclk),
            .rst_n (s_axi_aresetn),
            .flush (flush),
            .push  (push[c]),
            .pop   (pop[c]),
            .wdata (wr.din),
            .rdata (head[c]),
            .full  (fifo_full[c]),
            .empty (fifo_empty[c])
        );

        always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
            if (!s_axi_aresetn) begin
                freq_r  <= '0;
                amp_r   <= '0;
                phase_r <= '0;
                ofs_r   <= '0;
                mode_r  <= 1'b0;
            end else if (pop[c]) begin
                case (opcode_e'(head[c][OP_MSB:OP_LSB]))
                    OP_SET_FREQ: freq_r <= head[c][47:0];
                    OP_SET_AMP_PHASE: begin
                        amp_r   <= head[c][27:14];
                        phase_r <= head[c][13:0];
                    end
                    OP_SET_OFFSET: ofs_r  <= head[c][13:0];
                    OP_SET_MODE:   mode_r <= head[c][0];
                    default: ;
                endcase
            end
        end

        assign freq[FREQ_W*c +: FREQ_W]     = freq_r;
        assign amp[AMP_W*c +: AMP_W]        = amp_r;
        assign phase[AMP_W*c +: AMP_W]      = phase_r;
        assign amp_offset[AMP_W*c +: AMP_W] = ofs_r;
        assign dac_mode[c]                  = mode_r;
    end

    // a fresh error in the clear cycle wins over err_clr
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            update       <= '0;
            overflow_err <= '0;
            late_err     <= '0;
            chan_err     <= 1'b0;
        end else begin
            update       <= pop;
            overflow_err <= (overflow_err & ~{N_CH{err_clr}}) | ovf_set;
            late_err     <= (late_err & ~{N_CH{err_clr}}) | (pop & late);
            chan_err     <= (chan_err & ~err_clr) | bad_set;
        end
    end

endmodule

// File: tb/tb_dac_event_sequencer.sv
// Directed bench for dac_event_sequencer, N_CH=4, DEPTH=16, LATE_TOL=50.
// Inputs change and outputs are sampled on the falling edge.
module tb_dac_event_sequencer;
    import dac_seq_pkg::*;

    localparam int          N_CH     = 4;
    localparam int          DEPTH    = 16;
    localparam logic [63:0] LATE_TOL = 64'd50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic        err_clr = 1'b0;
    logic [63:0] counter = '0;

    logic [FREQ_W*N_CH-1:0] freq;
    logic [AMP_W*N_CH-1:0]  amp;
    logic [AMP_W*N_CH-1:0]  phase;
    logic [AMP_W*N_CH-1:0]  amp_offset;
    logic [N_CH-1:0]        dac_mode;
    logic [N_CH-1:0]        update;
    logic [N_CH-1:0]        overflow_err;
    logic [N_CH-1:0]        late_err;
    logic                   chan_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_event_sequencer_if #(.N_CH(N_CH)) wr_if ();

    dac_event_sequencer #(
        .N_CH     (N_CH),
        .DEPTH    (DEPTH),
        .LATE_TOL (LATE_TOL)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .run           (run),
        .flush         (flush),
        .err_clr       (err_clr),
        .counter       (counter),
        .wr            (wr_if.slave),
        .freq          (freq),
        .amp           (amp),
        .phase         (phase),
        .amp_offset    (amp_offset),
        .dac_mode      (dac_mode),
        .update        (update),
        .overflow_err  (overflow_err),
        .late_err      (late_err),
        .chan_err      (chan_err)
    );

    function automatic logic [127:0] ev(input logic [63:0] ts,
                                        input logic [7:0] ch,
                                        input logic [3:0] op,
                                        input logic [51:0] pl);
        return {ts, ch, op, pl};
    endfunction

    function automatic logic [47:0] fq(input int c);
        return freq[48*c +: 48];
    endfunction

    task automatic push_evt(input logic [63:0] ts, input logic [7:0] ch,
                            input logic [3:0] op, input logic [51:0] pl);
        wr_if.wr_en = 1'b1;
        wr_if.din   = ev(ts, ch, op, pl);
        @(negedge clk);
        wr_if.wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        wr_if.wr_en = 1'b0;
        wr_if.din   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_if.empty !== 4'hF) begin
            errors++;
            $display("FAIL reset_empty: got %h want f", wr_if.empty);
        end
        checks++;
        if (wr_if.full !== 4'h0) begin
            errors++;
            $display("FAIL reset_full: got %h want 0", wr_if.full);
        end
        checks++;
        if ({freq, amp, phase, amp_offset} !== '0) begin
            errors++;
            $display("FAIL reset_params: not all zero");
        end
        checks++;
        if ({dac_mode, update, overflow_err, late_err, chan_err} !== '0) begin
            errors++;
            $display("FAIL reset_flags: got %h want 0",
                     {dac_mode, update, overflow_err, late_err, chan_err});
        end
    endtask

    task automatic test_single();
        run = 1'b1;
        counter = 64'd0;
        push_evt(64'd100, 8'd2, 4'd0, 52'h1234);
        for (int t = 0; t < 100; t++) begin
            counter = 64'(t);
            @(negedge clk);
            checks++;
            if (fq(2) !== 48'h0 || update !== 4'h0) begin
                errors++;
                $display("FAIL single_early t=%0d: freq2=%h upd=%b want 0/0000",
                         t, fq(2), update);
            end
        end
        counter = 64'd100;
        @(negedge clk);
        checks++;
        if (fq(2) !== 48'h1234 || update !== 4'b0100) begin
            errors++;
            $display("FAIL single_apply: freq2=%h upd=%b want 1234/0100",
                     fq(2), update);
        end
        @(negedge clk);
        checks++;
        if (update !== 4'h0 || wr_if.empty[2] !== 1'b1 || late_err !== 4'h0) begin
            errors++;
            $display("FAIL single_after: upd=%b empty2=%b late=%b want 0000/1/0000",
                     update, wr_if.empty[2], late_err);
        end
        run = 1'b0;
    endtask

    task automatic test_overflow();
        int cnt;
        counter = 64'd0;
        for (int i = 0; i < 16; i++)
            push_evt(64'd0, 8'd0, 4'd1, (52'(i) << 14) | 52'(i + 100));
        checks++;
        if (wr_if.full[0] !== 1'b1 || overflow_err !== 4'h0) begin
            errors++;
            $display("FAIL ovf_full16: full0=%b ovf=%b want 1/0000",
                     wr_if.full[0], overflow_err);
        end
        push_evt(64'd0, 8'd0, 4'd1, (52'd16 << 14) | 52'd116);
        checks++;
        if (overflow_err !== 4'b0001 || wr_if.full[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_17th: ovf=%b full0=%b want 0001/1",
                     overflow_err, wr_if.full[0]);
        end
        run = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (update[0]) cnt++;
        end
        run = 1'b0;
        checks++;
        if (cnt !== 16) begin
            errors++;
            $display("FAIL ovf_drain_count: got %0d want 16", cnt);
        end
        checks++;
        if (amp[13:0] !== 14'd15 || phase[13:0] !== 14'd115 ||
            wr_if.empty[0] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_last: amp0=%0d phase0=%0d empty0=%b want 15/115/1",
                     amp[13:0], phase[13:0], wr_if.empty[0]);
        end
        pulse_clr();
        checks++;
        if (overflow_err !== 4'h0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0000", overflow_err);
        end
    endtask

    task automatic test_late();
        counter = 64'd500;
        run = 1'b1;
        push_evt(64'd450, 8'd1, 4'd3, 52'h1);
        @(negedge clk);
        checks++;
        if (dac_mode !== 4'b0010 || update !== 4'b0010 || late_err !== 4'h0) begin
            errors++;
            $display("FAIL late_edge: mode=%b upd=%b late=%b want 0010/0010/0000",
                     dac_mode, update, late_err);
        end
        push_evt(64'd400, 8'd1, 4'd2, 52'h0abc);
        @(negedge clk);
        checks++;
        if (amp_offset[27:14] !== 14'h0abc || update !== 4'b0010 ||
            late_err !== 4'b0010) begin
            errors++;
            $display("FAIL late_set: ofs1=%h upd=%b late=%b want 0abc/0010/0010",
                     amp_offset[27:14], update, late_err);
        end
        run = 1'b0;
        pulse_clr();
        checks++;
        if (late_err !== 4'h0) begin
            errors++;
            $display("FAIL late_clear: got %b want 0000", late_err);
        end
    endtask

    task automatic test_chan_err();
        counter = 64'd0;
        run = 1'b1;
        push_evt(64'd0, 8'd7, 4'd0, 52'h1);
        @(negedge clk);
        checks++;
        if (chan_err !== 1'b1 || wr_if.empty !== 4'hF || update !== 4'h0) begin
            errors++;
            $display("FAIL chan_bad_ch: err=%b empty=%h upd=%b want 1/f/0000",
                     chan_err, wr_if.empty, update);
        end
        pulse_clr();
        checks++;
        if (chan_err !== 1'b0) begin
            errors++;
            $display("FAIL chan_clear: got %b want 0", chan_err);
        end
        push_evt(64'd0, 8'd1, 4'd9, 52'h1);
        @(negedge clk);
        checks++;
        if (chan_err !== 1'b1 || wr_if.empty !== 4'hF || update !== 4'h0) begin
            errors++;
            $display("FAIL chan_bad_op: err=%b empty=%h upd=%b want 1/f/0000",
                     chan_err, wr_if.empty, update);
        end
        run = 1'b0;
        pulse_clr();
    endtask

    task automatic test_flush();
        counter = 64'd0;
        for (int i = 0; i < 3; i++)
            push_evt(64'd0, 8'd3, 4'd0, 52'hAAAA + 52'(i));
        checks++;
        if (wr_if.empty[3] !== 1'b0) begin
            errors++;
            $display("FAIL flush_queued: empty3=%b want 0", wr_if.empty[3]);
        end
        flush = 1'b1;
        run = 1'b1;
        wr_if.wr_en = 1'b1;
        wr_if.din = ev(64'd0, 8'd3, 4'd0, 52'hBBBB);
        @(negedge clk);
        flush = 1'b0;
        wr_if.wr_en = 1'b0;
        checks++;
        if (wr_if.empty !== 4'hF || update !== 4'h0) begin
            errors++;
            $display("FAIL flush_state: empty=%h upd=%b want f/0000",
                     wr_if.empty, update);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (update !== 4'h0) begin
                errors++;
                $display("FAIL flush_noupd: upd=%b want 0000", update);
            end
        end
        run = 1'b0;
        checks++;
        if (fq(3) !== 48'h0 || overflow_err !== 4'h0 || chan_err !== 1'b0) begin
            errors++;
            $display("FAIL flush_regs: freq3=%h ovf=%b chan=%b want 0/0000/0",
                     fq(3), overflow_err, chan_err);
        end
    endtask

    task automatic test_back_to_back();
        counter = 64'd1000;
        push_evt(64'd1000, 8'd0, 4'd0, 52'h111111);
        push_evt(64'd1000, 8'd1, 4'd0, 52'h222222);
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (update !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_update: got %b want 0011", update);
        end
        checks++;
        if (fq(0) !== 48'h111111 || fq(1) !== 48'h222222 ||
            fq(2) !== 48'h1234 || fq(3) !== 48'h0) begin
            errors++;
            $display("FAIL b2b_freq: %h %h %h %h want 111111 222222 1234 0",
                     fq(0), fq(1), fq(2), fq(3));
        end
        @(negedge clk);
        checks++;
        if (update !== 4'h0) begin
            errors++;
            $display("FAIL b2b_pulse: got %b want 0000", update);
        end
        run = 1'b0;
    endtask

    task automatic test_reset_midstream();
        counter = 64'd1000;
        push_evt(64'd2000, 8'd2, 4'd0, 52'h9999);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (wr_if.empty !== 4'hF || freq !== '0 || dac_mode !== 4'h0) begin
            errors++;
            $display("FAIL rst_mid_clear: empty=%h mode=%b want f/0000",
                     wr_if.empty, dac_mode);
        end
        push_evt(64'd0, 8'd2, 4'd0, 52'h7777);
        checks++;
        if (wr_if.empty[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_first_wr: empty2=%b want 0", wr_if.empty[2]);
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (fq(2) !== 48'h7777 || update !== 4'b0100) begin
            errors++;
            $display("FAIL rst_mid_apply: freq2=%h upd=%b want 7777/0100",
                     fq(2), update);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_late();
        test_chan_err();
        test_flush();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
